rand_interval_timer: RTL and testbench
======================================

RAND_INTERVAL_TIMER -- requirements
Module: rand_interval_timer

Interface
REQ-001 Parameter MIN_DELAY, default 12'd100: minimum delay in ticks added to the masked random value.
REQ-002 Parameter RANGE_MASK, default 12'h3FF: AND-mask applied to random_in before addition.
REQ-003 Parameter TICK_DIV, default 16'd50000: clock cycles per tick; legal values 1..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 random_in  input  12  random word from the upstream 12-bit LFSR generator, sampled only on start acceptance.
REQ-007 start  input  1  request to arm the timer; level-sampled.
REQ-008 abort  input  1  cancel a running interval.
REQ-009 busy  output  1  high while an interval is counting.
REQ-010 fire  output  1  one-cycle pulse at interval expiry.
REQ-011 aborted  output  1  one-cycle pulse when an interval is cancelled.
REQ-012 delay_value  output  12  delay (in ticks) captured for the current/last interval.
REQ-013 fire_count  output  8  number of fire pulses since reset, wraps 255->0.

Function
REQ-014 States: IDLE, COUNT, FIRE; all outputs registered.
REQ-015 IDLE: start=1 and abort=0 at an edge -> COUNT; delay_value, tick counter and prescaler load on that same edge.
REQ-016 Delay arithmetic: 13-bit sum MIN_DELAY + (random_in & RANGE_MASK), saturated to 12'hFFF.
REQ-017 Prescaler counts 0..TICK_DIV-1 in COUNT; a tick occurs on the edge where it equals TICK_DIV-1, then clears to 0.
REQ-018 On a tick: tick counter != 0 -> decrement; tick counter == 0 -> FIRE.
REQ-019 fire is high for exactly the cycle spent in FIRE, i.e. after (delay_value+1)*TICK_DIV edges counted from the accepting edge.
REQ-020 FIRE -> IDLE on next edge; fire_count increments on entry to FIRE.
REQ-021 busy is high exactly while in COUNT.
REQ-022 abort=1 in COUNT -> IDLE next edge, aborted high one cycle, no fire, fire_count unchanged; abort wins over a tick on the same edge.
REQ-023 abort in IDLE or FIRE is ignored; start and abort both high in IDLE -> remain IDLE, no aborted pulse.
REQ-024 start in COUNT or FIRE is ignored (not queued).
REQ-025 delay_value holds its last loaded value in IDLE.

Reset
REQ-026 rst_n low asynchronously forces IDLE; busy, fire, aborted, delay_value, fire_count, prescaler and tick counter to 0, including mid-interval.
REQ-027 After rst_n deasserts, first start is accepted no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 Macro RAND_TIMER_AUTO_REARM_EN defined: FIRE -> COUNT directly, reloading delay_value from random_in on that edge per REQ-016 (fire still one cycle, busy low only in FIRE); abort is the only exit to IDLE.
REQ-029 Macro undefined: FIRE -> IDLE per REQ-020; no auto-rearm logic synthesized.

Verification
REQ-030 TICK_DIV=1, MIN_DELAY=0, RANGE_MASK=FFF, random_in=12'h005, start at edge N -> delay_value=5, busy edges N..N+5, fire high only in cycle after edge N+6, fire_count=1.
REQ-031 MIN_DELAY=4000, RANGE_MASK=FFF, random_in=12'hFFF -> delay_value=12'hFFF (saturated); random_in=12'hABC, RANGE_MASK=00F -> delay_value=4012.
REQ-032 TICK_DIV=4, delay 3, abort after 8 edges in COUNT -> aborted one cycle, busy low, no fire, fire_count unchanged.
REQ-033 start=abort=1 in IDLE -> state IDLE, busy/aborted stay 0; start pulses during COUNT -> no change to delay_value or fire timing.
REQ-034 rst_n low mid-COUNT -> all outputs 0 immediately (before next clk edge); 256 completed intervals -> fire_count wraps to 0.
REQ-035 With RAND_TIMER_AUTO_REARM_EN, TICK_DIV=1, MIN_DELAY=2, RANGE_MASK=0 -> fire every 4 cycles continuously until abort; without it, single fire then IDLE.

Source files
------------

// File: rtl/rand_interval_timer.sv
// rand_interval_timer: arms on start, waits (delay+1) ticks of TICK_DIV clocks,
// where delay = MIN_DELAY + (random_in & RANGE_MASK) saturated to 12 bits,
// then pulses fire for one cycle. abort cancels a running interval.
// Optional feature macro: RAND_TIMER_AUTO_REARM_EN -- when defined the timer
// reloads a fresh delay and restarts counting straight out of FIRE.
module rand_interval_timer #(
   parameter logic [11:0] MIN_DELAY  = 12'd100,
   parameter logic [11:0] RANGE_MASK = 12'h3FF,
   parameter logic [15:0] TICK_DIV   = 16'd50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] random_in,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        fire,
   output logic        aborted,
   output logic [11:0] delay_value,
   output logic [7:0]  fire_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRE  = 2'd2
   } state_t;

   localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;

   state_t      state_r, state_n;
   logic [15:0] presc_r, presc_n;
   logic [11:0] tick_r, tick_n;
   logic [11:0] delay_n;
   logic [7:0]  fire_count_n;
   logic        aborted_n;

   // Masked random word plus minimum delay, clamped at the 12-bit ceiling.
   function automatic logic [11:0] calc_delay(input logic [11:0] rnd);
      logic [12:0] sum;
      sum = {1'b0, MIN_DELAY} + {1'b0, rnd & RANGE_MASK};
      if (sum[12]) begin
         calc_delay = 12'hFFF;
      end else begin
         calc_delay = sum[11:0];
      end
   endfunction

   // Next-state, prescaler, tick counter and output-event computation.
   always_comb begin
      state_n      = state_r;
      presc_n      = presc_r;
      tick_n       = tick_r;
      delay_n      = delay_value;
      fire_count_n = fire_count;
      aborted_n    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && !abort) begin
               state_n = ST_COUNT;
               delay_n = calc_delay(random_in);
               tick_n  = delay_n;
               presc_n = 16'd0;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_COUNT: begin
            // abort takes priority over a tick landing on the same edge
            if (abort) begin
               state_n   = ST_IDLE;
               aborted_n = 1'b1;
               presc_n   = 16'd0;
            end else if (presc_r == TICK_LAST) begin
               presc_n = 16'd0;
               if (tick_r != 12'd0) begin
                  tick_n = tick_r - 12'd1;
               end else begin
                  state_n      = ST_FIRE;
                  fire_count_n = fire_count + 8'd1;
               end
            end else begin
               presc_n = presc_r + 16'd1;
            end
         end
         ST_FIRE: begin
`ifdef RAND_TIMER_AUTO_REARM_EN
            state_n = ST_COUNT;
            delay_n = calc_delay(random_in);
            tick_n  = delay_n;
            presc_n = 16'd0;
`else
            state_n = ST_IDLE;
`endif
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, counters and all outputs registered; async reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         presc_r     <= 16'd0;
         tick_r      <= 12'd0;
         busy        <= 1'b0;
         fire        <= 1'b0;
         aborted     <= 1'b0;
         delay_value <= 12'd0;
         fire_count  <= 8'd0;
      end else begin
         state_r     <= state_n;
         presc_r     <= presc_n;
         tick_r      <= tick_n;
         busy        <= (state_n == ST_COUNT);
         fire        <= (state_n == ST_FIRE);
         aborted     <= aborted_n;
         delay_value <= delay_n;
         fire_count  <= fire_count_n;
      end
   end

endmodule

// File: tb/tb_rand_interval_timer.sv
// Self-checking bench for rand_interval_timer. Two instances with different
// parameters are driven side by side and compared every cycle against an
// interval-level reference model (remaining-edge countdown per interval).
module tb_rand_interval_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
   logic [11:0] rnd_a = 12'd0, rnd_b = 12'd0;
   logic        busy_a, fire_a, aborted_a, busy_b, fire_b, aborted_b;
   logic [11:0] dv_a, dv_b;
   logic [7:0]  fc_a, fc_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // A: fast ticks, full random range
   rand_interval_timer #(.MIN_DELAY(12'd0), .RANGE_MASK(12'hFFF), .TICK_DIV(16'd1)) dut_a (
      .clk(clk), .rst_n(rst_n), .random_in(rnd_a), .start(start_a), .abort(abort_a),
      .busy(busy_a), .fire(fire_a), .aborted(aborted_a), .delay_value(dv_a), .fire_count(fc_a));

   // B: prescaled ticks, large minimum delay for saturation checks
   rand_interval_timer #(.MIN_DELAY(12'd4000), .RANGE_MASK(12'h0FF), .TICK_DIV(16'd4)) dut_b (
      .clk(clk), .rst_n(rst_n), .random_in(rnd_b), .start(start_b), .abort(abort_b),
      .busy(busy_b), .fire(fire_b), .aborted(aborted_b), .delay_value(dv_b), .fire_count(fc_b));

   typedef struct { int st; int rem; int dv; int fc; int ab; } mdl_t;  // st: 0 idle,1 count,2 fire
   mdl_t ma, mb;

`ifdef RAND_TIMER_AUTO_REARM_EN
   localparam bit REARM = 1'b1;
`else
   localparam bit REARM = 1'b0;
`endif

   function automatic int sat_delay(int mn, int mask, int r);
      int v;
      v = mn + (r & mask);
      return (v > 4095) ? 4095 : v;
   endfunction

   // One clock edge of the reference model: an interval lasts (dv+1)*td edges.
   function automatic mdl_t model_step(mdl_t m, bit s, bit a, int r, int td, int mn, int mask);
      mdl_t n;
      n = m;
      n.ab = 0;
      case (m.st)
         0: if (s && !a) begin
               n.st = 1; n.dv = sat_delay(mn, mask, r); n.rem = (n.dv + 1) * td;
            end
         1: if (a) begin
               n.st = 0; n.ab = 1;
            end else begin
               n.rem = m.rem - 1;
               if (n.rem == 0) begin n.st = 2; n.fc = (m.fc + 1) % 256; end
            end
         default: if (REARM) begin
               n.st = 1; n.dv = sat_delay(mn, mask, r); n.rem = (n.dv + 1) * td;
            end else begin
               n.st = 0;
            end
      endcase
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_models();
      chk("A.busy", 32'(busy_a), 32'(ma.st == 1));
      chk("A.fire", 32'(fire_a), 32'(ma.st == 2));
      chk("A.aborted", 32'(aborted_a), 32'(ma.ab));
      chk("A.delay_value", 32'(dv_a), 32'(ma.dv));
      chk("A.fire_count", 32'(fc_a), 32'(ma.fc));
      chk("B.busy", 32'(busy_b), 32'(mb.st == 1));
      chk("B.fire", 32'(fire_b), 32'(mb.st == 2));
      chk("B.aborted", 32'(aborted_b), 32'(mb.ab));
      chk("B.delay_value", 32'(dv_b), 32'(mb.dv));
      chk("B.fire_count", 32'(fc_b), 32'(mb.fc));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".A.busy"}, 32'(busy_a), 32'd0);
      chk({tag, ".A.fire"}, 32'(fire_a), 32'd0);
      chk({tag, ".A.aborted"}, 32'(aborted_a), 32'd0);
      chk({tag, ".A.dv"}, 32'(dv_a), 32'd0);
      chk({tag, ".A.fc"}, 32'(fc_a), 32'd0);
      chk({tag, ".B.busy"}, 32'(busy_b), 32'd0);
      chk({tag, ".B.dv"}, 32'(dv_b), 32'd0);
      chk({tag, ".B.fc"}, 32'(fc_b), 32'd0);
   endtask

   // Drive inputs, take one rising edge, advance models, compare on falling edge.
   task automatic cycle(input bit sa, input bit aa, input logic [11:0] ra,
                        input bit sb, input bit ab, input logic [11:0] rb);
      start_a = sa; abort_a = aa; rnd_a = ra;
      start_b = sb; abort_b = ab; rnd_b = rb;
      @(posedge clk);
      ma = model_step(ma, sa, aa, int'(ra), 1, 0, 12'hFFF);
      mb = model_step(mb, sb, ab, int'(rb), 4, 4000, 12'h0FF);
      @(negedge clk);
      check_models();
   endtask

   task automatic idle_a(input logic [11:0] ra);
      cycle(1'b0, 1'b0, ra, 1'b0, 1'b0, 12'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [11:0] sat_rnd [5] = '{12'hFFF, 12'h05F, 12'h05E, 12'hABC, 12'h00C};
   logic [11:0] sat_exp [5] = '{12'hFFF, 12'hFFF, 12'hFFE, 12'hFFF, 12'hFAC};

   initial begin
      int fires;
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // delay 5 at one clock per tick: busy for 6 cycles, then one fire cycle
      cycle(1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 12'd0);
      chk("d5.dv", 32'(dv_a), 32'd5);
      chk("d5.busy0", 32'(busy_a), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         idle_a(12'h005);
         chk("d5.busy", 32'(busy_a), 32'(k <= 5));
         chk("d5.fire", 32'(fire_a), 32'(k == 6));
      end
      chk("d5.fc", 32'(fc_a), 32'd1);
      cycle(1'b0, 1'b1, 12'h005, 1'b0, 1'b0, 12'd0);

      // start together with abort in IDLE does nothing
      cycle(1'b1, 1'b1, 12'h007, 1'b0, 1'b0, 12'd0);
      chk("sa.busy", 32'(busy_a), 32'd0);
      chk("sa.aborted", 32'(aborted_a), 32'd0);

      // start pulses while counting are ignored
      cycle(1'b1, 1'b0, 12'h003, 1'b0, 1'b0, 12'd0);
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b1, 1'b0, 12'h009, 1'b0, 1'b0, 12'd0);
         chk("sc.dv", 32'(dv_a), 32'd3);
         chk("sc.fire", 32'(fire_a), 32'(k == 4));
      end
      cycle(1'b0, 1'b1, 12'h009, 1'b0, 1'b0, 12'd0);
      cycle(1'b0, 1'b1, 12'h009, 1'b0, 1'b0, 12'd0);

      // delay 2: periodic every 4 cycles with auto-rearm, single fire without
      fires = 0;
      cycle(1'b1, 1'b0, 12'h002, 1'b0, 1'b0, 12'd0);
      for (int k = 1; k <= 20; k++) begin
         idle_a(12'h002);
         if (fire_a) fires++;
      end
      chk("rearm.fires", 32'(fires), REARM ? 32'd5 : 32'd1);
      cycle(1'b0, 1'b1, 12'h002, 1'b0, 1'b0, 12'd0);
      cycle(1'b0, 1'b1, 12'h002, 1'b0, 1'b0, 12'd0);

      // B: saturating delay arithmetic, then abort after 8 edges in COUNT
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, sat_rnd[i]);
         chk("sat.dv", 32'(dv_b), 32'(sat_exp[i]));
         repeat (8) cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
         cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b1, 12'd0);
         chk("ab.aborted", 32'(aborted_b), 32'd1);
         chk("ab.busy", 32'(busy_b), 32'd0);
         chk("ab.fc", 32'(fc_b), 32'd0);
         cycle(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
         chk("ab.pulse", 32'(aborted_b), 32'd0);
         chk("ab.nofire", 32'(fire_b), 32'd0);
      end

      // reset in the middle of an interval clears outputs before the next edge
      cycle(1'b1, 1'b0, 12'h800, 1'b1, 1'b0, 12'h010);
      repeat (10) idle_a(12'h800);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      rst_n = 1'b1;

      // 256 zero-delay intervals wrap fire_count back to 0
      for (int i = 1; i <= 256; i++) begin
         cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'd0);
         idle_a(12'h000);
         idle_a(12'h000);
         if (!REARM && i == 255) chk("wrap.255", 32'(fc_a), 32'd255);
      end
      if (!REARM) chk("wrap.0", 32'(fc_a), 32'd0);
      cycle(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 12'd0);
      cycle(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 12'd0);

      // randomized traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
         rb = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(80, 111)) : 12'($urandom_range(0, 4095));
         cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0), ra,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0), rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
